spi_bus_arbiter: RTL and testbench
==================================

Name: spi_bus_arbiter

Overview:
- Shares the single SPI bus (spi_c/spi_d/spi_q) between two requesters: the flash loader (requester 0, selects flash_s) and the EEPROM persistence engine (requester 1, selects eeprom_s).
- Arbitrates per transaction and owns chip-select sequencing and minimum deselect time.
- Contains the byte shift engine: SPI mode 0, MSB first.
- Sits inside vicii between the config/persistence logic and the board SPI pins; runs on the dot4x clock.

Parameters:
- CLK_DIV, 4: clk_dot4x cycles per SCLK half-period; legal range ≥1.
- CS_IDLE, 8: minimum clk_dot4x cycles both chip selects stay high between transactions; legal range ≥1.
- TIMEOUT, 65535: idle cycles in HOLD before forced release. Used only with the optional feature.

Ports:
- clk_dot4x  in  1  dot4x clock.
- rst_n  in  1  asynchronous active-low reset.
- spi_lock  in  1  high: refuse new grants (cfg1 jumper).
- req  in  2  per-requester transaction request; held high for the whole transaction.
- gnt  out  2  one-hot grant.
- tx_data0  in  8  byte from requester 0.
- tx_data1  in  8  byte from requester 1.
- tx_valid  in  2  per-requester byte strobe.
- tx_ready  out  1  granted owner may strobe tx_valid.
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-cycle pulse; rx_data valid.
- busy  out  1  state != IDLE.
- flash_s  out  1  flash chip select, active low.
- eeprom_s  out  1  EEPROM chip select, active low.
- spi_c  out  1  SCLK.
- spi_d  out  1  MOSI.
- spi_q  in  1  MISO.

Behaviour:
- Clock and reset are decided: one clock, clk_dot4x; rst_n is asynchronous, active low.
- Reset values:
  - gnt=0, tx_ready=0, rx_valid=0, busy=0, rx_data=0.
  - flash_s=1, eeprom_s=1, spi_c=0, spi_d=0.
  - last_owner=1, so requester 0 wins the first tie.
- States: IDLE, HOLD, SHIFT, RELEASE.
- IDLE:
  - If spi_lock=0 and req!=0, choose a winner round-robin, preferring the requester other than last_owner.
  - Next cycle: gnt[w]=1, matching CS low, tx_ready=1, go to HOLD.
  - Grant latency is 1 cycle after req is sampled.
  - spi_lock=1 holds the block in IDLE regardless of req.
- HOLD (CS low, spi_c=0):
  - tx_valid[owner]=1: latch the owner's tx_data, drive spi_d=bit7, tx_ready=0, go to SHIFT.
  - tx_valid from the non-owner is ignored.
  - req[owner]=0: go to RELEASE. This takes priority over a simultaneous tx_valid.
- SHIFT:
  - 8 bits; each bit is CLK_DIV cycles with spi_c=0, then CLK_DIV cycles with spi_c=1.
  - spi_q is sampled on the rising SCLK edge.
  - spi_d advances at the falling edge.
  - Byte time is 16*CLK_DIV cycles.
  - After the 8th high phase: spi_c=0, rx_data updated, rx_valid pulses 1 cycle, tx_ready=1, return to HOLD.
  - req dropped mid-byte: the byte still completes (rx_valid still pulses), then RELEASE.
- RELEASE:
  - gnt=0, both CS high, last_owner=owner.
  - Count CS_IDLE cycles, then go to IDLE.
  - req re-asserted during RELEASE waits for IDLE.
- spi_lock asserted mid-transaction: no effect until the block returns to IDLE.
- Both chip selects are never low simultaneously, which is guaranteed by construction.
- rst_n mid-transaction: CS high and spi_c low immediately (asynchronously); the partial byte is discarded with no rx_valid.
- Counters: divider of width clog2(CLK_DIV); bit counter 3 bits; idle counter of width clog2(CS_IDLE+1).

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in HOLD and clears on any owner tx_valid.
  - At TIMEOUT the block forces RELEASE even with req still high, and sets sticky output timeout_err (1 bit); timeout_err clears on rst_n.
  - The owner must drop req and re-request.
- Undefined: no counter, no port; HOLD waits indefinitely.

Decomposition:
- Shared package (common.vh style include):
  - state encodings ST_IDLE/ST_HOLD/ST_SHIFT/ST_RELEASE.
  - requester indices REQ_FLASH=0, REQ_EEPROM=1.
  - default CLK_DIV/CS_IDLE.
- One natural sub-module: spi_shift_byte, covering divider, 8-bit shift register, rx capture and done pulse. It has start/done handshake only; the arbiter FSM stays in the parent.

Test Plan:
- Reset: rst_n low → flash_s=1, eeprom_s=1, spi_c=0, gnt=0. Assert req=2'b11 after reset → gnt=01 one cycle later, flash_s=0.
- Byte loopback: spi_q tied to spi_d, CLK_DIV=4, owner sends 0xA5 → rx_data=0xA5, rx_valid pulses exactly 64 cycles after tx_valid, 8 rising spi_c edges.
- Round-robin: both req held; requester 0 drops req after 1 byte → both CS high for exactly 8 cycles, then gnt=10 and eeprom_s=0.
- Lock: spi_lock=1 with req=01 → gnt stays 0 for 100 cycles. Release spi_lock → gnt=01 next cycle. Lock asserted mid-byte → byte completes normally.
- Drop mid-byte: req[owner]=0 at bit 3 of 0x3C → byte completes, rx_valid pulses, then CS high. Non-owner tx_valid during HOLD → no SHIFT.
- Async reset mid-SHIFT: rst_n low at bit 5 → CS high and spi_c low within the same cycle, no rx_valid. With SPI_ARB_TIMEOUT_EN and TIMEOUT=20: owner idle in HOLD → forced release at cycle 20, timeout_err=1.

Source files
------------

// File: rtl/spi_bus_arbiter_pkg.sv
// Shared definitions for the SPI bus arbiter: FSM states, requester indices
// and default timing parameters.
package spi_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_SHIFT,
    ST_RELEASE
  } arb_state_e;

  localparam logic REQ_FLASH  = 1'b0;
  localparam logic REQ_EEPROM = 1'b1;

  localparam int unsigned DEF_CLK_DIV = 4;
  localparam int unsigned DEF_CS_IDLE = 8;

  function automatic logic [1:0] grant_vec(input logic sel);
    return (sel == REQ_EEPROM) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_shift_byte.sv
// SPI mode 0 byte engine, MSB first: SCLK divider, TX/RX shift registers,
// RX capture and a combinational done strobe on the final falling edge.
module spi_shift_byte
  import spi_bus_arbiter_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] tx_byte_i,
  input  logic       spi_q_i,
  output logic       spi_c_o,
  output logic       spi_d_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       done_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             active_q, active_d;
  logic             phase_q, phase_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;

  logic half_end, rise, fall;

  assign half_end = active_q && (div_q == DIV_LAST);
  assign rise     = half_end && !phase_q;
  assign fall     = half_end && phase_q;
  assign done_o   = fall && (bit_q == 3'd7);

  always_comb begin
    active_d   = active_q;
    phase_d    = phase_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    if (start_i && !active_q) begin
      active_d = 1'b1;
      phase_d  = 1'b0;
      div_d    = '0;
      bit_d    = '0;
      tx_d     = tx_byte_i;
    end else if (active_q) begin
      if (half_end) begin
        div_d   = '0;
        phase_d = ~phase_q;
      end else begin
        div_d = div_q + 1'b1;
      end
      // MISO is captured on the rising SCLK edge; MOSI advances on the falling one.
      if (rise) rx_d = {rx_q[6:0], spi_q_i};
      if (fall) begin
        if (bit_q == 3'd7) begin
          active_d   = 1'b0;
          rx_byte_d  = rx_q;
          rx_valid_d = 1'b1;
        end else begin
          bit_d = bit_q + 3'd1;
          tx_d  = {tx_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q   <= 1'b0;
      phase_q    <= 1'b0;
      div_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      active_q   <= active_d;
      phase_q    <= phase_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign spi_c_o    = phase_q;
  assign spi_d_o    = active_q & tx_q[7];
  assign rx_byte_o  = rx_byte_q;
  assign rx_valid_o = rx_valid_q;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Two-requester SPI bus arbiter with chip-select sequencing and deselect time.
// Optional HOLD watchdog and timeout_err port enabled by SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned CS_IDLE = DEF_CS_IDLE
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 65535
`endif
) (
  input  logic       clk_dot4x,
  input  logic       rst_n,
  input  logic       spi_lock,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  input  logic [1:0] tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       flash_s,
  output logic       eeprom_s,
  output logic       spi_c,
  output logic       spi_d,
  input  logic       spi_q
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  output logic       timeout_err
`endif
);

  localparam int unsigned IDLE_W = $clog2(CS_IDLE + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(CS_IDLE - 1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        timeout_err_q, timeout_err_d;
`endif

  logic       start;
  logic       shift_done;
  logic       owning;
  logic [7:0] tx_byte;

  assign tx_byte = (owner_q == REQ_EEPROM) ? tx_data1 : tx_data0;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    idle_cnt_d   = idle_cnt_q;
    start        = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    to_cnt_d      = '0;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!spi_lock && (req != 2'b00)) begin
          if (req == 2'b11) owner_d = ~last_owner_q;
          else              owner_d = req[REQ_EEPROM] ? REQ_EEPROM : REQ_FLASH;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!req[owner_q]) begin
          state_d      = ST_RELEASE;
          last_owner_d = owner_q;
          idle_cnt_d   = IDLE_W'(1);
        end else if (tx_valid[owner_q]) begin
          start   = 1'b1;
          state_d = ST_SHIFT;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (to_cnt_q == 16'(TIMEOUT - 1)) begin
          state_d       = ST_RELEASE;
          last_owner_d  = owner_q;
          idle_cnt_d    = IDLE_W'(1);
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`endif
      end
      ST_SHIFT: begin
        if (shift_done) begin
          if (!req[owner_q]) begin
            state_d      = ST_RELEASE;
            last_owner_d = owner_q;
            idle_cnt_d   = IDLE_W'(1);
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_RELEASE: begin
        // The IDLE arbitration cycle is the final deselect cycle, so RELEASE
        // lasts CS_IDLE-1 cycles (at least one).
        if (idle_cnt_q >= IDLE_LAST) state_d = ST_IDLE;
        else                         idle_cnt_d = idle_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= REQ_FLASH;
      last_owner_q <= REQ_EEPROM;
      idle_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`endif

  spi_shift_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .clk_i      (clk_dot4x),
    .rst_ni     (rst_n),
    .start_i    (start),
    .tx_byte_i  (tx_byte),
    .spi_q_i    (spi_q),
    .spi_c_o    (spi_c),
    .spi_d_o    (spi_d),
    .rx_byte_o  (rx_data),
    .rx_valid_o (rx_valid),
    .done_o     (shift_done)
  );

  // Chip selects decode from a single owner register, so both can never be low.
  assign owning   = (state_q == ST_HOLD) || (state_q == ST_SHIFT);
  assign gnt      = owning ? grant_vec(owner_q) : 2'b00;
  assign flash_s  = !(owning && (owner_q == REQ_FLASH));
  assign eeprom_s = !(owning && (owner_q == REQ_EEPROM));
  assign tx_ready = (state_q == ST_HOLD);
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter with MISO looped back to MOSI.
module tb_spi_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_lock;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [7:0] tx_data0, tx_data1;
  logic [1:0] tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       flash_s, eeprom_s;
  logic       spi_c, spi_d, spi_q;
`ifdef SPI_ARB_TIMEOUT_EN
  logic       timeout_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_edge = 0;
  int rise_total = 0;
  int rise_snap = 0;
  int rx_count = 0;
  logic sc_prev = 1'b0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign spi_q = spi_d;

  spi_bus_arbiter #(
    .CLK_DIV(4),
    .CS_IDLE(8)
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    .TIMEOUT(20)
`endif
  ) dut (
    .clk_dot4x (clk),
    .rst_n     (rst_n),
    .spi_lock  (spi_lock),
    .req       (req),
    .gnt       (gnt),
    .tx_data0  (tx_data0),
    .tx_data1  (tx_data1),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .flash_s   (flash_s),
    .eeprom_s  (eeprom_s),
    .spi_c     (spi_c),
    .spi_d     (spi_d),
    .spi_q     (spi_q)
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic who, input logic [7:0] d);
    for (int i = 0; i < 100 && !tx_ready; i++) @(negedge clk);
    check("tx_ready_wait", 32'(tx_ready), 32'd1);
    if (who) tx_data1 = d; else tx_data0 = d;
    tx_valid = who ? 2'b10 : 2'b01;
    sb.push_back(d);
    tx_edge   = cyc + 1;
    rise_snap = rise_total;
    @(negedge clk);
    tx_valid = 2'b00;
    check("spi_d_msb", 32'(spi_d), 32'(d[7]));
    check("tx_ready_shift", 32'(tx_ready), 32'd0);
  endtask

  task automatic wait_rx();
    for (int i = 0; i < 300 && !rx_valid; i++) @(negedge clk);
    check("rx_seen", 32'(rx_valid), 32'd1);
  endtask

  task automatic check_pulse();
    @(negedge clk);
    check("rx_pulse_1cyc", 32'(rx_valid), 32'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic wait_gnt(input logic [1:0] g);
    for (int i = 0; i < 50 && gnt !== g; i++) @(negedge clk);
    check("wait_gnt", 32'(gnt), 32'(g));
  endtask

  // Output monitor: SCLK rise counting and scoreboard pop on each rx_valid.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (spi_c && !sc_prev) rise_total++;
      sc_prev = spi_c;
      if (rx_valid) begin
        rx_count++;
        if (sb.size() == 0) begin
          check("rx_unexpected", 32'(rx_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rx_data", 32'(rx_data), 32'(e));
          check("rx_latency", 32'(cyc - tx_edge), 32'd64);
          check("sclk_rises", 32'(rise_total - rise_snap), 32'd8);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int hi, bad, n0, n;
    rst_n = 1'b0; spi_lock = 1'b0; req = 2'b00;
    tx_valid = 2'b00; tx_data0 = '0; tx_data1 = '0;
    repeat (3) @(negedge clk);
    check("rst_flash_s", 32'(flash_s), 32'd1);
    check("rst_eeprom_s", 32'(eeprom_s), 32'd1);
    check("rst_spi_c", 32'(spi_c), 32'd0);
    check("rst_spi_d", 32'(spi_d), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy_ready", 32'({busy, tx_ready, rx_valid}), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;

    // First tie goes to requester 0, one cycle after req is sampled.
    @(negedge clk);
    req = 2'b11;
    check("gnt_before_edge", 32'(gnt), 32'd0);
    @(negedge clk);
    check("first_gnt", 32'(gnt), 32'b01);
    check("first_flash_s", 32'(flash_s), 32'd0);
    check("first_eeprom_s", 32'(eeprom_s), 32'd1);
    check("first_tx_ready", 32'(tx_ready), 32'd1);

    // Loopback byte, then round-robin handover with deselect time.
    send_byte(1'b0, 8'hA5);
    wait_rx();
    req = 2'b10;
    hi = 0;
    for (int i = 0; i < 40 && eeprom_s; i++) begin
      @(negedge clk);
      if (flash_s && eeprom_s) hi++;
    end
    check("cs_idle_cycles", 32'(hi), 32'd8);
    check("rr_gnt", 32'(gnt), 32'b10);
    check("rr_flash_s", 32'(flash_s), 32'd1);

    send_byte(1'b1, 8'h96);
    wait_rx();
    check_pulse();

    // Non-owner strobe in HOLD must not start a byte.
    n0 = rise_total;
    tx_data0 = 8'hFF;
    tx_valid = 2'b01;
    @(negedge clk);
    tx_valid = 2'b00;
    check("nonowner_ready", 32'(tx_ready), 32'd1);
    repeat (10) @(negedge clk);
    check("nonowner_sclk", 32'(rise_total - n0), 32'd0);
    check("nonowner_hold", 32'({busy, tx_ready}), 32'b11);
    req = 2'b00;
    wait_idle();

    // Lock blocks grants in IDLE only.
    spi_lock = 1'b1;
    req = 2'b01;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (gnt != 2'b00) bad++;
    end
    check("lock_gnt_cycles", 32'(bad), 32'd0);
    check("lock_busy", 32'(busy), 32'd0);
    spi_lock = 1'b0;
    @(negedge clk);
    check("unlock_gnt", 32'(gnt), 32'b01);
    send_byte(1'b0, 8'hC3);
    repeat (20) @(negedge clk);
    spi_lock = 1'b1;
    wait_rx();
    check_pulse();
    req = 2'b00;
    wait_idle();
    req = 2'b01;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (gnt != 2'b00) bad++;
    end
    check("relock_gnt_cycles", 32'(bad), 32'd0);
    req = 2'b00;
    spi_lock = 1'b0;
    @(negedge clk);

    // req dropped mid-byte: byte completes, then chip select releases.
    req = 2'b01;
    wait_gnt(2'b01);
    send_byte(1'b0, 8'h3C);
    repeat (26) @(negedge clk);
    req = 2'b00;
    wait_rx();
    check("drop_flash_s", 32'(flash_s), 32'd1);
    check("drop_gnt", 32'(gnt), 32'd0);
    check("drop_release_busy", 32'(busy), 32'd1);
    check_pulse();
    wait_idle();

    // Asynchronous reset in the middle of a byte.
    req = 2'b01;
    wait_gnt(2'b01);
    send_byte(1'b0, 8'hF0);
    repeat (45) @(negedge clk);
    check("b5_sclk_high", 32'(spi_c), 32'd1);
    n0 = rx_count;
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_flash_s", 32'(flash_s), 32'd1);
    check("arst_eeprom_s", 32'(eeprom_s), 32'd1);
    check("arst_spi_c", 32'(spi_c), 32'd0);
    check("arst_gnt", 32'(gnt), 32'd0);
    req = 2'b00;
    repeat (3) @(negedge clk);
    check("arst_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("arst_no_rx", 32'(rx_count), 32'(n0));

`ifdef SPI_ARB_TIMEOUT_EN
    req = 2'b01;
    wait_gnt(2'b01);
    n = 0;
    while (gnt != 2'b00 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd20);
    check("timeout_err", 32'(timeout_err), 32'd1);
    req = 2'b00;
    wait_idle();
`else
    n = 0;
    check("final_idle_gnt", 32'(gnt), 32'(n));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
